// File: rtl/rf_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_seq_ctrl_pkg
// Shared definitions for the register-file sequencer and the ALU it drives:
//   - default datapath widths
//   - sequencer state encoding (IDLE, INIT0, INIT1, RUN, DONE = 0..4)
//   - ALU opcode constants (common to the sequencer and the ALU)
// ---------------------------------------------------------------------------
package rf_seq_ctrl_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_OP_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT0 = 3'd1,
        ST_INIT1 = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [RF_OP_W-1:0] ALU_NOP = 5'h00;
    localparam logic [RF_OP_W-1:0] ALU_ADD = 5'h01;
    localparam logic [RF_OP_W-1:0] ALU_SUB = 5'h02;
    localparam logic [RF_OP_W-1:0] ALU_AND = 5'h03;
    localparam logic [RF_OP_W-1:0] ALU_OR  = 5'h04;
    localparam logic [RF_OP_W-1:0] ALU_XOR = 5'h05;

endpackage

// File: rtl/rf_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rf_seq_ctrl
// Sequencer that sits in front of a register file and ALU. On start it
// writes seed0/seed1 into R0/R1 and then runs N recurrence steps
// R[i+2] = R[i] op R[i+1], one register-file write per clock.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, honoured only in IDLE or DONE
//   seed0, seed1        values for R0/R1 (latched at start)
//   count               number of steps N (latched, clamped to MAX_N)
//   op                  ALU opcode for the run (latched at start)
//   rd_addr             readout address while not busy
//   rf_rd1_data         register-file port-1 read data
//   alu_y               ALU result
//   rf_rd1_addr/rd2     register-file read addresses
//   rf_wr_addr/data/en  register-file write port
//   alu_op              opcode presented to the ALU
//   rd_data             readout data (0 while busy)
//   busy                high in INIT0, INIT1, RUN
//   done                high in DONE until the next start
// ---------------------------------------------------------------------------
module rf_seq_ctrl
    import rf_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int OP_W   = RF_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [ADDR_W-1:0] count,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_rd1_data,
    input  logic [DATA_W-1:0] alu_y,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    output logic [ADDR_W-1:0] rf_rd2_addr,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_en,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    // Largest step count that keeps the last write inside the register file.
    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'((2 ** ADDR_W) - 2);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_step;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_seed0;
    logic [DATA_W-1:0] r_seed1;
    logic [OP_W-1:0]   r_op;

    logic              w_start_ok;
    logic              w_busy;
    logic              w_last_step;
    logic [ADDR_W-1:0] w_count_clamped;

    assign w_start_ok      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_count_clamped = (count > MAX_N) ? MAX_N : count;
    // Only evaluated in RUN, where r_count is known to be non-zero.
    assign w_last_step     = (r_step == (r_count - ADDR_W'(1)));

    // State, step counter and run parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_count <= '0;
            r_seed0 <= '0;
            r_seed1 <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_step  <= '0;
                r_count <= w_count_clamped;
                r_seed0 <= seed0;
                r_seed1 <= seed1;
                r_op    <= op;
            end else if (r_state == ST_RUN) begin
                r_step <= r_step + ADDR_W'(1);
            end
        end
    end

    // Next state and Moore output decode.
    always_comb begin
        w_state_next = r_state;
        rf_rd1_addr  = '0;
        rf_rd2_addr  = '0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        rf_wr_en     = 1'b0;
        alu_op       = r_op;
        w_busy       = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rf_rd1_addr = rd_addr;
                if (start) w_state_next = ST_INIT0;
            end
            ST_INIT0: begin
                w_busy       = 1'b1;
                rf_wr_en     = 1'b1;
                rf_wr_addr   = '0;
                rf_wr_data   = r_seed0;
                w_state_next = ST_INIT1;
            end
            ST_INIT1: begin
                w_busy       = 1'b1;
                rf_wr_en     = 1'b1;
                rf_wr_addr   = ADDR_W'(1);
                rf_wr_data   = r_seed1;
                w_state_next = (r_count == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                w_busy      = 1'b1;
                rf_wr_en    = 1'b1;
                rf_rd1_addr = r_step;
                rf_rd2_addr = r_step + ADDR_W'(1);
                rf_wr_addr  = r_step + ADDR_W'(2);
                rf_wr_data  = alu_y;
                if (w_last_step) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                rf_rd1_addr = rd_addr;
                if (start) w_state_next = ST_INIT0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = w_busy;
    // Port 1 is busy with sequencing reads during a run; hide it.
    assign rd_data = w_busy ? '0 : rf_rd1_data;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
module tb_rf_seq_ctrl;
    import rf_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] seed0, seed1;
    logic [4:0]  count, op, rd_addr;
    logic [31:0] rf_rd1_data, rf_rd2_data, alu_y;
    logic [4:0]  rf_rd1_addr, rf_rd2_addr, rf_wr_addr, alu_op;
    logic [31:0] rf_wr_data, rd_data;
    logic        rf_wr_en, busy, done;

    always #5 clk = ~clk;

    rf_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .seed0(seed0), .seed1(seed1), .count(count), .op(op),
        .rd_addr(rd_addr), .rf_rd1_data(rf_rd1_data), .alu_y(alu_y),
        .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
        .alu_op(alu_op), .rd_data(rd_data), .busy(busy), .done(done)
    );

    // Environment: register file and ALU behind the sequencer.
    logic [31:0] rf [32] = '{default: '0};
    int          wr_cnt [32] = '{default: 0};
    int          base [32];

    always_comb rf_rd1_data = rf[rf_rd1_addr];
    always_comb rf_rd2_data = rf[rf_rd2_addr];
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_y = rf_rd1_data + rf_rd2_data;
            ALU_SUB: alu_y = rf_rd1_data - rf_rd2_data;
            ALU_XOR: alu_y = rf_rd1_data ^ rf_rd2_data;
            default: alu_y = '0;
        endcase
    end

    always @(posedge clk) begin
        if (rf_wr_en === 1'b1) begin
            rf[rf_wr_addr]     <= rf_wr_data;
            wr_cnt[rf_wr_addr] <= wr_cnt[rf_wr_addr] + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic snap();
        for (int i = 0; i < 32; i++) base[i] = wr_cnt[i];
    endtask

    // Drives start for exactly one edge (edge k); on return cyc=1 (cycle k+1).
    task automatic do_start(input logic [31:0] s0, input logic [31:0] s1,
                            input logic [4:0] n, input logic [4:0] o);
        snap();
        seed0 = s0; seed1 = s1; count = n; op = o; start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        while (done !== 1'b1 && cyc < 200) tick();
        checks++;
        if (done !== 1'b1 || cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s done_cycle got=k+%0d (done=%b) exp=k+%0d", name, cyc, done, exp_cyc);
        end else
            $display("run %s: done at cycle k+%0d", name, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; seed0 = '0; seed1 = '0;
        count = '0; op = '0; rd_addr = '0;
        tick(); tick();
        checks++;
        if ({busy, done, rf_wr_en} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, rf_wr_en});
        end
        checks++;
        if ({rf_rd1_addr, rf_rd2_addr, rf_wr_addr, alu_op} !== 20'h0) begin
            errors++; $display("FAIL reset_addr_op got=%h exp=0", {rf_rd1_addr, rf_rd2_addr, rf_wr_addr, alu_op});
        end
        checks++;
        if (rf_wr_data !== 32'h0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_data wr=%h rd=%h exp=0/0", rf_wr_data, rd_data);
        end
        rst_n = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_fib();
        int exp_r [5] = '{2, 3, 5, 8, 13};
        do_start(32'd1, 32'd1, 5'd5, ALU_ADD);
        checks++;  // INIT0
        if (busy !== 1'b1 || rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd1) begin
            errors++; $display("FAIL fib_init0 busy=%b en=%b addr=%0d data=%0d exp=1/1/0/1", busy, rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        tick();
        checks++;  // INIT1
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 32'd1) begin
            errors++; $display("FAIL fib_init1 en=%b addr=%0d data=%0d exp=1/1/1", rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        tick();
        checks++;  // RUN step 0
        if (rf_rd1_addr !== 5'd0 || rf_rd2_addr !== 5'd1 || rf_wr_addr !== 5'd2 ||
            alu_op !== ALU_ADD || rf_wr_data !== 32'd2) begin
            errors++; $display("FAIL fib_run0 rd1=%0d rd2=%0d wa=%0d op=%0d wd=%0d exp=0/1/2/1/2",
                               rf_rd1_addr, rf_rd2_addr, rf_wr_addr, alu_op, rf_wr_data);
        end
        checks++;  // readout hidden while busy (R0=1 is on port 1)
        if (rd_data !== 32'd0) begin
            errors++; $display("FAIL fib_rd_busy got=%0d exp=0", rd_data);
        end
        wait_done(8, "fib");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rf[i+2] !== exp_r[i]) begin
                errors++; $display("FAIL fib_R%0d got=%0d exp=%0d", i + 2, rf[i+2], exp_r[i]);
            end
        end
        rd_addr = 5'd6;
        #1;
        checks++;
        if (rd_data !== 32'd13) begin
            errors++; $display("FAIL fib_readout got=%0d exp=13", rd_data);
        end
        $display("fib: R2..R6=%0d,%0d,%0d,%0d,%0d rd_data[6]=%0d", rf[2], rf[3], rf[4], rf[5], rf[6], rd_data);
    endtask

    task automatic test_count_zero();
        do_start(32'd7, 32'd9, 5'd0, ALU_ADD);
        wait_done(3, "count0");
        checks++;
        if (rf[0] !== 32'd7 || rf[1] !== 32'd9) begin
            errors++; $display("FAIL count0_seeds got=%0d/%0d exp=7/9", rf[0], rf[1]);
        end
        checks++;
        if (wr_cnt[0] - base[0] != 1 || wr_cnt[1] - base[1] != 1 || wr_cnt[2] - base[2] != 0) begin
            errors++; $display("FAIL count0_writes R0=%0d R1=%0d R2=%0d exp=1/1/0",
                               wr_cnt[0] - base[0], wr_cnt[1] - base[1], wr_cnt[2] - base[2]);
        end
    endtask

    task automatic test_clamp();
        int total;
        do_start(32'd0, 32'd1, 5'd31, ALU_ADD);
        wait_done(33, "clamp");
        total = 0;
        for (int i = 0; i < 32; i++) total += wr_cnt[i] - base[i];
        checks++;
        if (total != 32 || wr_cnt[0] - base[0] != 1 || wr_cnt[1] - base[1] != 1 || wr_cnt[31] - base[31] != 1) begin
            errors++; $display("FAIL clamp_writes total=%0d R0=%0d R1=%0d R31=%0d exp=32/1/1/1",
                               total, wr_cnt[0] - base[0], wr_cnt[1] - base[1], wr_cnt[31] - base[31]);
        end
        checks++;  // R31 = Fibonacci(31)
        if (rf[31] !== 32'd1346269) begin
            errors++; $display("FAIL clamp_R31 got=%0d exp=1346269", rf[31]);
        end
    endtask

    task automatic test_start_while_busy();
        do_start(32'd1, 32'd1, 5'd5, ALU_ADD);
        tick(); tick();  // now RUN step 0
        seed0 = 32'd100; seed1 = 32'd200; count = 5'd3; op = ALU_SUB; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8, "busy_start");
        checks++;
        if (rf[2] !== 32'd2 || rf[4] !== 32'd5 || rf[6] !== 32'd13 || alu_op !== ALU_ADD) begin
            errors++; $display("FAIL busy_start_results R2=%0d R4=%0d R6=%0d op=%0d exp=2/5/13/1",
                               rf[2], rf[4], rf[6], alu_op);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(32'd1, 32'd1, 5'd5, ALU_ADD);
        tick(); tick(); tick(); tick();  // RUN step 2
        checks++;
        if (rf_wr_addr !== 5'd4 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_pre wa=%0d busy=%b exp=4/1", rf_wr_addr, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rf_wr_en} !== 3'b000) begin
            errors++; $display("FAIL midrst_async got=%b exp=000", {busy, done, rf_wr_en});
        end
        tick();
        checks++;
        if ({busy, done, rf_wr_en} !== 3'b000) begin
            errors++; $display("FAIL midrst_next got=%b exp=000", {busy, done, rf_wr_en});
        end
        rst_n = 1'b1;
        tick();
        $display("midrst: reset asserted at RUN step 2");
        do_start(32'd4, 32'd5, 5'd2, ALU_ADD);
        wait_done(5, "rerun");
        checks++;
        if (rf[2] !== 32'd9 || rf[3] !== 32'd14) begin
            errors++; $display("FAIL rerun_results R2=%0d R3=%0d exp=9/14", rf[2], rf[3]);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_pre_done got=%b exp=1", done);
        end
        do_start(32'd20, 32'd3, 5'd2, ALU_SUB);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_init0 done=%b busy=%b exp=0/1", done, busy);
        end
        wait_done(5, "b2b_sub");
        checks++;
        if (rf[2] !== 32'd17 || rf[3] !== 32'hFFFF_FFF2) begin
            errors++; $display("FAIL b2b_results R2=%0d R3=%0d exp=17/-14", $signed(rf[2]), $signed(rf[3]));
        end
        checks++;
        if (alu_op !== ALU_SUB) begin
            errors++; $display("FAIL b2b_done_op got=%0d exp=2", alu_op);
        end
    endtask

    initial begin
        test_reset();
        test_fib();
        test_count_zero();
        test_clamp();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
